cbc_decrypt_mode: RTL
=====================

// Module: cbc_decrypt_mode
// PURPOSE
//  CBC-mode decryptor; inverse of the CBC encryptor. Decrypts up to MAX_BLOCKS 64-bit
//  blocks through one gage_ingage_decipher core: P[i] = D_K(C[i]) ^ C[i-1], C[-1] = IV.
//  Sits beside the encryptor in the crypto processor; the bus layout matches, so
//  encryptor ciphertext/iv/num_blocks feed this block directly.
// PARAMETERS
//  BLOCK_SIZE          64    block width in bits (= sponge RATE)
//  KEY_SIZE            64    key width in bits
//  CAPACITY            512   sponge capacity, passed to the core
//  INTERNAL_STATE_SIZE 576   sponge state width, passed to the core
//  ROUNDS              32    permutation rounds, passed to the core
//  MAX_BLOCKS          1024  max blocks per message
// PORTS
//  clk         in   1                     clock, rising edge
//  reset_n     in   1                     async active-low reset
//  start       in   1                     start request, sampled only in IDLE
//  key         in   KEY_SIZE              key, latched at accepted start
//  iv          in   BLOCK_SIZE            IV, latched at accepted start
//  ciphertext  in   BLOCK_SIZE*MAX_BLOCKS blocks, block i at [i*BLOCK_SIZE +: BLOCK_SIZE]; hold stable until done
//  num_blocks  in   16                    block count, latched at accepted start; valid 1..MAX_BLOCKS
//  plaintext   out  BLOCK_SIZE*MAX_BLOCKS recovered blocks, same layout
//  busy        out  1                     high from accepted start until cycle after done
//  done        out  1                     one-cycle completion pulse
//  err         out  1                     one-cycle pulse with done when num_blocks invalid
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; plaintext, busy, done, err, chain, blk_cnt, dec_start = 0.
//    Reset mid-message aborts immediately; core driven with .reset(~reset_n).
//  - FSM: IDLE -> LOAD -> DECRYPT -> (LOAD | DONE) -> IDLE.
//  - IDLE: start=1 -> latch key/iv/num_blocks, chain<=iv, blk_cnt<=0, busy<=1.
//    num_blocks==0 or >MAX_BLOCKS -> DONE with err flag, plaintext untouched; else LOAD.
//  - LOAD: dec_start<=1 for exactly one cycle; core input = ciphertext[blk_cnt]; -> DECRYPT.
//  - DECRYPT: dec_start<=0; on core done pulse: plaintext[blk_cnt] <= core_out ^ chain;
//    chain <= ciphertext[blk_cnt]; last block (blk_cnt==n_lat-1) -> DONE, else blk_cnt+1, -> LOAD.
//  - DONE: done=1 (err=1 if invalid) for one cycle, busy<=0, -> IDLE.
//  - start while not IDLE is ignored; start held high after done relaunches from IDLE.
//  - Only block blk_cnt's slice is written; slices >= num_blocks keep prior values.
//  - Latency start->done: 2 + N*(L+2) cycles, L = core start->done latency; invalid count: 2.
//  - blk_cnt 16 bits; compare against latched count, no wrap for n <= MAX_BLOCKS.
//  - Core done outside DECRYPT is ignored.
// STRUCTURE
//  - cbc_pkg: FSM state encodings (IDLE/LOAD/DECRYPT/DONE) and default BLOCK_SIZE/KEY_SIZE/
//    MAX_BLOCKS constants, shared with the encryptor.
//  - One sub-module: gage_ingage_decipher (start/done handshake, parameters passed through).
//  - Block-select mux on ciphertext and XOR/chain registers stay in this module.
// TESTING
//  - Reset: reset_n=0 mid-DECRYPT of block 3 -> next cycle busy=0, done=0, plaintext=0; restart works.
//  - Single block: key=64'h0123456789ABCDEF, iv=64'h0, C from encryptor of P=64'hDEADBEEFCAFEF00D,
//    num_blocks=1 -> done pulse once, plaintext[63:0]=64'hDEADBEEFCAFEF00D, err=0.
//  - Round trip: 8 random blocks, iv=64'hA5A5A5A5A5A5A5A5, encrypt with CBC encryptor then decrypt ->
//    all 8 slices match, latency = 2+8*(L+2).
//  - Chaining: two identical C blocks, iv=0 -> P[1] = P[0] ^ C[0] ^ 0 verified vs model.
//  - Invalid: num_blocks=0 then num_blocks=1025 -> done and err high together 2 cycles after start, plaintext unchanged.
//  - Start while busy: pulse start during block 2 of 4, change iv -> ignored, output uses first iv.

Source files
------------

// File: rtl/cbc_pkg.sv
// Shared definitions for the CBC encrypt/decrypt blocks: default sizes,
// FSM state encodings and a block-count validity helper.
package cbc_pkg;

  localparam int CBC_BLOCK_SIZE = 64;
  localparam int CBC_KEY_SIZE   = 64;
  localparam int CBC_CAPACITY   = 512;
  localparam int CBC_STATE_SIZE = 576;
  localparam int CBC_ROUNDS     = 32;
  localparam int CBC_MAX_BLOCKS = 1024;

  // FSM encodings, kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_DECRYPT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // A message is legal when it has at least one block and fits the bus.
  function automatic logic blocks_valid(input logic [15:0] n, input int max_blocks);
    return (n != 16'd0) && (int'(n) <= max_blocks);
  endfunction

endpackage

// File: rtl/gage_ingage_decipher.sv
// Iterative block decipher core. One Feistel round per cycle, run in reverse
// key order so that it inverts the matching encipher core. The data path is
// the sponge rate (INTERNAL_STATE_SIZE - CAPACITY), which equals BLOCK_SIZE.
// start is accepted only while idle; done pulses for one cycle with dout valid.
module gage_ingage_decipher #(
  parameter int BLOCK_SIZE          = 64,
  parameter int KEY_SIZE            = 64,
  parameter int CAPACITY            = 512,
  parameter int INTERNAL_STATE_SIZE = 576,
  parameter int ROUNDS              = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] din,
  output logic [BLOCK_SIZE-1:0] dout,
  output logic                  done
);

  localparam int RATE = INTERNAL_STATE_SIZE - CAPACITY;
  localparam int HW   = RATE / 2;
  localparam int KW   = KEY_SIZE / 2;
  localparam int RW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [HW-1:0] DELTA = HW'(32'h9E3779B9);

  logic [HW-1:0] st_l;
  logic [HW-1:0] st_r;
  logic [RW-1:0] rnd;
  logic          running;
  logic [HW-1:0] rkey;

  // Round function shared with the encipher side.
  function automatic logic [HW-1:0] mix(input logic [HW-1:0] x, input logic [HW-1:0] k);
    return ((x << 4) ^ (x >> 5)) + (x ^ k);
  endfunction

  // Round key: alternate key halves, tweaked by a per-round multiple of DELTA.
  assign rkey = (rnd[0] ? key[KW-1:0] : key[KEY_SIZE-1:KW]) ^ (DELTA * (HW'(rnd) + HW'(1)));

  assign dout = {st_l, st_r};

  // Load on start, then undo one Feistel round per cycle from the last round down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_l    <= '0;
      st_r    <= '0;
      rnd     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (running) begin
        st_l <= st_r ^ mix(st_l, rkey);
        st_r <= st_l;
        if (rnd == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          rnd <= rnd - RW'(1);
        end
      end else if (start) begin
        st_l    <= din[BLOCK_SIZE-1 -: HW];
        st_r    <= din[HW-1:0];
        rnd     <= RW'(ROUNDS - 1);
        running <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbc_decrypt_mode.sv
// CBC-mode decryptor: P[i] = D_K(C[i]) ^ C[i-1], with C[-1] = IV.
// Blocks are fed one at a time through a single decipher core; the block
// select mux and the XOR/chain registers live here. Bus layout matches the
// CBC encryptor so its outputs can be connected straight in.
module cbc_decrypt_mode
  import cbc_pkg::*;
#(
  parameter int BLOCK_SIZE          = CBC_BLOCK_SIZE,
  parameter int KEY_SIZE            = CBC_KEY_SIZE,
  parameter int CAPACITY            = CBC_CAPACITY,
  parameter int INTERNAL_STATE_SIZE = CBC_STATE_SIZE,
  parameter int ROUNDS              = CBC_ROUNDS,
  parameter int MAX_BLOCKS          = CBC_MAX_BLOCKS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [KEY_SIZE-1:0]              key,
  input  logic [BLOCK_SIZE-1:0]            iv,
  input  logic [BLOCK_SIZE*MAX_BLOCKS-1:0] ciphertext,
  input  logic [15:0]                      num_blocks,
  output logic [BLOCK_SIZE*MAX_BLOCKS-1:0] plaintext,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int BUS_W = BLOCK_SIZE * MAX_BLOCKS;
  localparam int IW    = $clog2(BUS_W);

  logic [1:0]            state;
  logic [KEY_SIZE-1:0]   key_lat;
  logic [BLOCK_SIZE-1:0] chain;
  logic [15:0]           n_lat;
  logic [15:0]           blk_cnt;
  logic                  err_lat;
  logic                  dec_start;
  logic [IW-1:0]         blk_base;
  logic [BLOCK_SIZE-1:0] ct_blk;
  logic [BLOCK_SIZE-1:0] core_out;
  logic                  core_done;

  // Bit offset of the current block on the ciphertext/plaintext buses.
  assign blk_base = IW'(blk_cnt) * IW'(BLOCK_SIZE);
  assign ct_blk   = ciphertext[blk_base +: BLOCK_SIZE];

  gage_ingage_decipher #(
    .BLOCK_SIZE          (BLOCK_SIZE),
    .KEY_SIZE            (KEY_SIZE),
    .CAPACITY            (CAPACITY),
    .INTERNAL_STATE_SIZE (INTERNAL_STATE_SIZE),
    .ROUNDS              (ROUNDS)
  ) u_core (
    .clk   (clk),
    .reset (~reset_n),
    .start (dec_start),
    .key   (key_lat),
    .din   (ct_blk),
    .dout  (core_out),
    .done  (core_done)
  );

  // Message sequencer: latch the request, walk the blocks, unchain, report.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // chain and plaintext must both read the old chain on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: plaintext is a register bus, not a RAM, so it takes the reset
      // like any other flop and a mid-message abort leaves it cleared.
      state     <= ST_IDLE;
      plaintext <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      chain     <= '0;
      blk_cnt   <= '0;
      dec_start <= 1'b0;
      key_lat   <= '0;
      n_lat     <= '0;
      err_lat   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_lat <= key;
            chain   <= iv;
            n_lat   <= num_blocks;
            blk_cnt <= '0;
            busy    <= 1'b1;
            if (blocks_valid(num_blocks, MAX_BLOCKS)) begin
              err_lat <= 1'b0;
              state   <= ST_LOAD;
            end else begin
              err_lat <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          dec_start <= 1'b1;
          state     <= ST_DECRYPT;
        end
        ST_DECRYPT: begin
          dec_start <= 1'b0;
          if (core_done) begin
            plaintext[blk_base +: BLOCK_SIZE] <= core_out ^ chain;
            chain <= ct_blk;
            if (blk_cnt == n_lat - 16'd1) begin
              state <= ST_DONE;
            end else begin
              blk_cnt <= blk_cnt + 16'd1;
              state   <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          err   <= err_lat;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
